dtree_mc_classifier: RTL and testbench

Multi-channel, parametrised-depth linear decision-tree spike classifier; successor to the single-channel tree core in the spike-sorting datapath. It accepts a channel-tagged feature vector and walks a per-channel complete binary tree held in on-chip node memory. Each internal node is evaluated with one signed MAC per feature per cycle. It emits a class ID, channel tag and depth on a ready/valid output with backpressure.

---
 rtl/dtree_pkg.sv | 40 ++++
 rtl/dtree_node_mac.sv | 37 +++
 rtl/memory_model.sv | 24 ++
 rtl/dtree_mc_classifier.sv | 185 ++++++++++++++++++
 tb/tb_dtree_mc_classifier.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/dtree_pkg.sv
// Shared types and sizing helpers for the multi-channel decision-tree classifier.
// Node word layout (MSB..LSB): {leaf, class, coeff[FEATURES-1:0], bias}.
package dtree_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MAC,
    S_DECIDE,
    S_OUT
  } state_e;

  function automatic int nodes_f(input int max_depth);
    return (1 << max_depth) - 1;
  endfunction

  function automatic int node_w_f(input int features, input int coeff_w, input int bias_w,
                                  input int class_w);
    return 1 + class_w + features * coeff_w + bias_w;
  endfunction

  function automatic int coeff_lsb_f(input int idx, input int coeff_w, input int bias_w);
    return bias_w + idx * coeff_w;
  endfunction

  function automatic int class_lsb_f(input int features, input int coeff_w, input int bias_w);
    return bias_w + features * coeff_w;
  endfunction

  function automatic int leaf_bit_f(input int features, input int coeff_w, input int bias_w,
                                    input int class_w);
    return bias_w + features * coeff_w + class_w;
  endfunction

  // Full-precision accumulator: bias plus FEATURES products can never overflow.
  function automatic int acc_w_f(input int in_w, input int coeff_w, input int features);
    return in_w + coeff_w + $clog2(features) + 1;
  endfunction

endpackage

// File: rtl/dtree_node_mac.sv
// Node accumulator: load scaled bias plus first product, then one signed product per cycle.
// acc_neg_o reflects the registered accumulator sign.
module dtree_node_mac
  import dtree_pkg::*;
#(
  parameter int IN_WIDTH    = 10,
  parameter int COEFF_WIDTH = 4,
  parameter int BIAS_WIDTH  = 4,
  parameter int ACC_W       = 17
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          en_i,
  input  logic                          load_i,
  input  logic signed [BIAS_WIDTH-1:0]  bias_i,
  input  logic signed [COEFF_WIDTH-1:0] coeff_i,
  input  logic signed [IN_WIDTH-1:0]    feat_i,
  output logic                          acc_neg_o
);

  logic signed [ACC_W-1:0] acc_q, acc_d, prod, base;

  always_comb begin
    prod  = ACC_W'(coeff_i) * ACC_W'(feat_i);
    base  = ACC_W'(bias_i) <<< (COEFF_WIDTH - 1);
    acc_d = acc_q;
    if (en_i) acc_d = (load_i ? base : acc_q) + prod;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_neg_o = acc_q[ACC_W-1];

endmodule

// File: rtl/memory_model.sv
// Simple dual-port node memory: one write port, one registered read port.
// Read data holds its value while re_i is low; contents are never reset.
module memory_model #(
  parameter int DW    = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/dtree_mc_classifier.sv
// Multi-channel decision-tree spike classifier, one sample in flight, ready/valid output.
// Define DTREE_PATH_OUT_EN to add out_path_o carrying the branch bits of the walk.
module dtree_mc_classifier
  import dtree_pkg::*;
#(
  parameter int FEATURES      = 3,
  parameter int IN_WIDTH      = 10,
  parameter int COEFF_WIDTH   = 4,
  parameter int BIAS_WIDTH    = 4,
  parameter int MAX_DEPTH     = 4,
  parameter int CHANNEL_COUNT = 4,
  parameter int CLASS_WIDTH   = 3,
  localparam int NODES   = nodes_f(MAX_DEPTH),
  localparam int NODE_W  = node_w_f(FEATURES, COEFF_WIDTH, BIAS_WIDTH, CLASS_WIDTH),
  localparam int CH_W    = $clog2(CHANNEL_COUNT),
  localparam int NODE_IW = $clog2(NODES),
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cfg_we_i,
  output logic                         cfg_ready_o,
  input  logic [CH_W-1:0]              cfg_ch_i,
  input  logic [NODE_IW-1:0]           cfg_node_i,
  input  logic [NODE_W-1:0]            cfg_data_i,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [CH_W-1:0]              in_ch_i,
  input  logic [FEATURES*IN_WIDTH-1:0] in_feat_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [CH_W-1:0]              out_ch_o,
  output logic [CLASS_WIDTH-1:0]       out_class_o,
  output logic [DEPTH_W-1:0]           out_depth_o,
`ifdef DTREE_PATH_OUT_EN
  output logic [MAX_DEPTH-1:0]         out_path_o,
`endif
  output logic                         out_err_o
);

  localparam int ACC_W     = acc_w_f(IN_WIDTH, COEFF_WIDTH, FEATURES);
  localparam int ADDR_W    = $clog2(CHANNEL_COUNT * NODES);
  localparam int IDX_W     = (FEATURES > 1) ? $clog2(FEATURES) : 1;
  localparam int CLASS_LSB = class_lsb_f(FEATURES, COEFF_WIDTH, BIAS_WIDTH);
  localparam int LEAF_BIT  = leaf_bit_f(FEATURES, COEFF_WIDTH, BIAS_WIDTH, CLASS_WIDTH);

  state_e                        state_q;
  logic [CH_W-1:0]               ch_q;
  logic [FEATURES*IN_WIDTH-1:0]  feat_q;
  logic [NODE_IW-1:0]            node_q;
  logic [DEPTH_W-1:0]            depth_q;
  logic [IDX_W-1:0]              idx_q;
  logic [CLASS_WIDTH-1:0]        class_q;
  logic                          err_q, out_valid_q;
  logic [CHANNEL_COUNT-1:0]      armed_q, arm_now;

  logic                          cfg_wr, accept, is_leaf, last_level, acc_neg;
  logic [ADDR_W-1:0]             wr_addr, rd_addr;
  logic [NODE_W-1:0]             node_dat;
  logic signed [COEFF_WIDTH-1:0] coeff_sel;
  logic signed [IN_WIDTH-1:0]    feat_sel;
  logic signed [BIAS_WIDTH-1:0]  bias_sel;

  assign cfg_wr     = cfg_we_i && (state_q == S_IDLE) && (int'(cfg_node_i) < NODES);
  assign arm_now    = (cfg_wr && cfg_node_i == '0) ? (CHANNEL_COUNT'(1) << cfg_ch_i) : '0;
  assign accept     = in_valid_i && (state_q == S_IDLE);
  assign wr_addr    = ADDR_W'(cfg_ch_i) * ADDR_W'(NODES) + ADDR_W'(cfg_node_i);
  assign rd_addr    = ADDR_W'(ch_q) * ADDR_W'(NODES) + ADDR_W'(node_q);
  assign is_leaf    = node_dat[LEAF_BIT];
  assign last_level = (depth_q == DEPTH_W'(MAX_DEPTH - 1));
  assign coeff_sel  = node_dat[coeff_lsb_f(int'(idx_q), COEFF_WIDTH, BIAS_WIDTH) +: COEFF_WIDTH];
  assign feat_sel   = feat_q[int'(idx_q)*IN_WIDTH +: IN_WIDTH];
  assign bias_sel   = node_dat[BIAS_WIDTH-1:0];

  memory_model #(.DW(NODE_W), .DEPTH(CHANNEL_COUNT * NODES), .AW(ADDR_W)) u_mem (
    .clk_i   (clk_i),
    .we_i    (cfg_wr),
    .waddr_i (wr_addr),
    .wdata_i (cfg_data_i),
    .re_i    (state_q == S_READ),
    .raddr_i (rd_addr),
    .rdata_o (node_dat)
  );

  dtree_node_mac #(
    .IN_WIDTH(IN_WIDTH), .COEFF_WIDTH(COEFF_WIDTH), .BIAS_WIDTH(BIAS_WIDTH), .ACC_W(ACC_W)
  ) u_mac (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      ((state_q == S_MAC) && !is_leaf),
    .load_i    (idx_q == '0),
    .bias_i    (bias_sel),
    .coeff_i   (coeff_sel),
    .feat_i    (feat_sel),
    .acc_neg_o (acc_neg)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      feat_q      <= '0;
      node_q      <= '0;
      depth_q     <= '0;
      idx_q       <= '0;
      class_q     <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      armed_q     <= '0;
    end else begin
      armed_q <= armed_q | arm_now;
      case (state_q)
        S_IDLE: if (accept) begin
          ch_q    <= in_ch_i;
          feat_q  <= in_feat_i;
          node_q  <= '0;
          depth_q <= '0;
          idx_q   <= '0;
          class_q <= '0;
          // A same-cycle write to node 0 arms the channel for this very sample.
          err_q   <= !(armed_q[in_ch_i] || arm_now[in_ch_i]);
          state_q <= S_READ;
        end
        S_READ: begin
          if (err_q) begin
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          if (is_leaf) begin
            class_q     <= node_dat[CLASS_LSB +: CLASS_WIDTH];
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (idx_q == IDX_W'(FEATURES - 1)) begin
            idx_q   <= '0;
            state_q <= S_DECIDE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        S_DECIDE: begin
          if (last_level) begin
            class_q     <= '0;
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            node_q  <= (node_q << 1) + (acc_neg ? NODE_IW'(1) : NODE_IW'(2));
            depth_q <= depth_q + DEPTH_W'(1);
            state_q <= S_READ;
          end
        end
        S_OUT: if (out_ready_i) begin
          out_valid_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef DTREE_PATH_OUT_EN
  logic [MAX_DEPTH-1:0] path_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                      path_q <= '0;
    else if (accept)                                  path_q <= '0;
    else if ((state_q == S_DECIDE) && !last_level)    path_q[depth_q] <= !acc_neg;
  end

  assign out_path_o = path_q;
`endif

  assign cfg_ready_o = (state_q == S_IDLE);
  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = out_valid_q;
  assign out_ch_o    = ch_q;
  assign out_class_o = class_q;
  assign out_depth_o = depth_q;
  assign out_err_o   = err_q;

endmodule

// File: tb/tb_dtree_mc_classifier.sv
// Directed bench for dtree_mc_classifier: hand-computed trees, latencies, backpressure and reset.
module tb_dtree_mc_classifier;

  logic        clk, rst_n;
  logic        cfg_we, cfg_ready;
  logic [1:0]  cfg_ch;
  logic [3:0]  cfg_node;
  logic [19:0] cfg_data;
  logic        in_valid, in_ready;
  logic [1:0]  in_ch;
  logic [29:0] in_feat;
  logic        out_valid, out_ready;
  logic [1:0]  out_ch;
  logic [2:0]  out_class;
  logic [2:0]  out_depth;
  logic        out_err;
`ifdef DTREE_PATH_OUT_EN
  logic [3:0]  out_path;
`endif

  int total;
  int bad;
  int lat;

  dtree_mc_classifier dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cfg_we_i    (cfg_we),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_node_i  (cfg_node),
    .cfg_data_i  (cfg_data),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_ch_i     (in_ch),
    .in_feat_i   (in_feat),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_ch_o    (out_ch),
    .out_class_o (out_class),
    .out_depth_o (out_depth),
`ifdef DTREE_PATH_OUT_EN
    .out_path_o  (out_path),
`endif
    .out_err_o   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [3:0] node, input logic [19:0] d);
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = ch; cfg_node = node; cfg_data = d;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Presents one sample and returns just after the accept edge.
  task automatic send(input logic [1:0] ch, input logic signed [9:0] f0,
                      input logic signed [9:0] f1, input logic signed [9:0] f2);
    @(negedge clk);
    check("in_ready_before_send", 32'(in_ready), 1);
    in_valid = 1'b1; in_ch = ch; in_feat = {f2, f1, f0};
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid; bounded.
  task automatic wait_out(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (out_valid !== 1'b1 && n < 60);
  endtask

  task automatic finish_out();
    @(posedge clk); #1;
    check("out_valid_after_handshake", 32'(out_valid), 0);
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_node = '0; cfg_data = '0;
    in_valid = 1'b0; in_ch = '0; in_feat = '0; out_ready = 1'b1;

    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_cfg_ready", 32'(cfg_ready), 1);
    check("rst_out_err", 32'(out_err), 0);
    check("rst_out_class", 32'(out_class), 0);
    check("rst_out_depth", 32'(out_depth), 0);
    @(negedge clk) rst_n = 1'b1;

    // ch0: root coeffs (1,0,0) bias 0; node1 leaf class 2; node2 leaf class 5
    cfg_write(2'd0, 4'd0, 20'h00010);
    cfg_write(2'd0, 4'd1, 20'hA0000);
    cfg_write(2'd0, 4'd2, 20'hD0000);

    // acc = -3 -> left
    send(2'd0, -10'sd3, 10'sd7, 10'sd7);
    wait_out(lat);
    check("left_latency", 32'(lat), 7);
    check("left_class", 32'(out_class), 2);
    check("left_depth", 32'(out_depth), 1);
    check("left_err", 32'(out_err), 0);
    check("left_ch", 32'(out_ch), 0);
    check("left_in_ready_busy", 32'(in_ready), 0);
`ifdef DTREE_PATH_OUT_EN
    check("left_path", 32'(out_path), 0);
`endif
    finish_out();

    // acc = 0 -> right
    send(2'd0, 10'sd0, 10'sd0, 10'sd0);
    wait_out(lat);
    check("right_latency", 32'(lat), 7);
    check("right_class", 32'(out_class), 5);
    check("right_depth", 32'(out_depth), 1);
`ifdef DTREE_PATH_OUT_EN
    check("right_path", 32'(out_path), 1);
`endif
    finish_out();

    // ch1: root is a leaf of class 6
    cfg_write(2'd1, 4'd0, 20'hE0000);
    send(2'd1, 10'sd5, -10'sd5, 10'sd1);
    wait_out(lat);
    check("ch1_latency", 32'(lat), 2);
    check("ch1_class", 32'(out_class), 6);
    check("ch1_depth", 32'(out_depth), 0);
    check("ch1_ch", 32'(out_ch), 1);
    finish_out();

    // ch2 never configured
    send(2'd2, 10'sd1, 10'sd1, 10'sd1);
    wait_out(lat);
    check("unarmed_latency", 32'(lat), 1);
    check("unarmed_err", 32'(out_err), 1);
    check("unarmed_class", 32'(out_class), 0);
    check("unarmed_ch", 32'(out_ch), 2);
    finish_out();

    // Backpressure: result held 20 cycles while a second sample waits
    out_ready = 1'b0;
    send(2'd1, 10'sd0, 10'sd0, 10'sd0);
    wait_out(lat);
    check("bp_latency", 32'(lat), 2);
    @(negedge clk);
    in_valid = 1'b1; in_ch = 2'd0; in_feat = {10'sd7, 10'sd7, -10'sd3};
    repeat (20) begin
      @(posedge clk); #1;
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_class", 32'(out_class), 6);
      check("bp_hold_in_ready", 32'(in_ready), 0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(out_valid), 0);
    check("bp_release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    check("bp_second_accepted", 32'(in_ready), 0);
    in_valid = 1'b0;
    wait_out(lat);
    check("bp_second_latency", 32'(lat), 7);
    check("bp_second_class", 32'(out_class), 2);
    check("bp_second_ch", 32'(out_ch), 0);
    finish_out();

    // ch3: every node internal, coeffs 0, bias +1 -> always right, 0->2->6->14
    for (int n = 0; n < 15; n++) cfg_write(2'd3, 4'(n), 20'h00001);
    send(2'd3, 10'sd100, -10'sd100, 10'sd50);
    wait_out(lat);
    check("deep_latency", 32'(lat), 20);
    check("deep_err", 32'(out_err), 1);
    check("deep_depth", 32'(out_depth), 3);
    check("deep_class", 32'(out_class), 0);
`ifdef DTREE_PATH_OUT_EN
    check("deep_path", 32'(out_path), 7);
`endif
    finish_out();

    // Config write to ch2 node 0 in the same cycle the ch2 sample is accepted
    @(negedge clk);
    cfg_we = 1'b1; cfg_ch = 2'd2; cfg_node = 4'd0; cfg_data = 20'hB0000;
    in_valid = 1'b1; in_ch = 2'd2; in_feat = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0; in_valid = 1'b0;
    wait_out(lat);
    check("samecycle_latency", 32'(lat), 2);
    check("samecycle_class", 32'(out_class), 3);
    check("samecycle_err", 32'(out_err), 0);
    finish_out();

    // Async reset in the middle of the ch0 walk
    send(2'd0, 10'sd0, 10'sd0, 10'sd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_valid", 32'(out_valid), 0);
    @(negedge clk) rst_n = 1'b1;
    #1;
    check("midrst_cfg_ready", 32'(cfg_ready), 1);
    send(2'd0, -10'sd3, 10'sd7, 10'sd7);
    wait_out(lat);
    check("midrst_latency", 32'(lat), 1);
    check("midrst_err", 32'(out_err), 1);
    check("midrst_class", 32'(out_class), 0);
    finish_out();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
